// File: rtl/rv32i_regdump_if.sv
// ---------------------------------------------------------------------------
// rv32i_regdump_if
//
// Stream bus carrying register snapshot beats from the regdump engine toward
// the debug transport.
//
//   m_valid_o  beat valid (driven by the engine)
//   m_ready_i  beat accepted when high together with m_valid_o (driven by sink)
//   m_addr_o   architectural register index of the beat
//   m_data_o   register value of the beat
//
// Modports:
//   master  the engine side (drives valid/addr/data, observes ready)
//   slave   the transport side (observes valid/addr/data, drives ready)
// ---------------------------------------------------------------------------
interface rv32i_regdump_if;

    logic        m_valid_o;
    logic        m_ready_i;
    logic [4:0]  m_addr_o;
    logic [31:0] m_data_o;

    modport master (
        output m_valid_o,
        output m_addr_o,
        output m_data_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_addr_o,
        input  m_data_o,
        output m_ready_i
    );

endinterface

// File: rtl/rv32i_regdump.sv
// ---------------------------------------------------------------------------
// rv32i_regdump
//
// Debug readout engine for the RV32I register file. On a start request it
// walks x[first]..x[last] (wrapping 31 -> 0) through one regfile read port
// and streams each value out as an {index, data} beat. The core is held in
// halt for the whole dump so writeback cannot disturb the snapshot.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_in      asynchronous active-low reset
//   start_i     dump request, only looked at while idle
//   first_i     first register index, captured with the accepted start
//   last_i      last register index, captured with the accepted start
//   abort_i     cancels a dump in progress; no done pulse follows
//   busy_o      high while a dump is in progress
//   halt_req_o  same as busy_o; core freezes register writes while high
//   done_o      one-cycle pulse after the final beat has been accepted
//   rs_o        regfile read address (the walking pointer)
//   rs_data_i   combinational regfile read data for rs_o
//   stream      beat output bus (master side)
// ---------------------------------------------------------------------------
module rv32i_regdump (
    input  logic                   clk_i,
    input  logic                   rst_in,
    input  logic                   start_i,
    input  logic [4:0]             first_i,
    input  logic [4:0]             last_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   halt_req_o,
    output logic                   done_o,
    output logic [4:0]             rs_o,
    input  logic [31:0]            rs_data_i,
    rv32i_regdump_if.master        stream
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q,   ptr_d;
    logic [4:0]  last_q,  last_d;
    logic [31:0] data_q,  data_d;
    logic [4:0]  addr_q,  addr_d;

    // State and datapath registers. Everything clears together so that the
    // outputs, all decoded from these registers, show reset values at once.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            last_q  <= 5'd0;
            data_q  <= 32'd0;
            addr_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic. The beat is captured into data_q/addr_q in FETCH so
    // that the stream stays stable during backpressure in SEND, regardless
    // of what the regfile port does. Abort takes priority over any handshake
    // so a cancelled dump never produces done. The pointer is 5 bits wide,
    // so incrementing past 31 naturally wraps to 0 for wrapped ranges.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        data_d  = data_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    ptr_d   = first_i;
                    last_d  = last_i;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    data_d  = rs_data_i;
                    addr_d  = ptr_q;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (stream.m_ready_i) begin
                    if (ptr_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = FETCH;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o           = (state_q != IDLE);
    assign halt_req_o       = busy_o;
    assign done_o           = (state_q == DONE);
    assign rs_o             = ptr_q;
    assign stream.m_valid_o = (state_q == SEND);
    assign stream.m_addr_o  = addr_q;
    assign stream.m_data_o  = data_q;

endmodule

// File: tb/tb_rv32i_regdump.sv
// ---------------------------------------------------------------------------
// tb_rv32i_regdump
//
// Self-checking bench for rv32i_regdump. A behavioural regfile array feeds
// the read port; expected beats are derived from the range rules (index
// (first + k) mod 32 for k below the beat count, data from the array).
// ---------------------------------------------------------------------------
module tb_rv32i_regdump;

    logic        clk_i = 1'b0;
    logic        rst_in;
    logic        start_i;
    logic [4:0]  first_i;
    logic [4:0]  last_i;
    logic        abort_i;
    logic        busy_o;
    logic        halt_req_o;
    logic        done_o;
    logic [4:0]  rs_o;
    logic [31:0] rs_data_i;
    logic [31:0] regfile [32];

    int n_checks = 0;
    int n_pass   = 0;

    rv32i_regdump_if bus ();

    rv32i_regdump dut (
        .clk_i      (clk_i),
        .rst_in     (rst_in),
        .start_i    (start_i),
        .first_i    (first_i),
        .last_i     (last_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .halt_req_o (halt_req_o),
        .done_o     (done_o),
        .rs_o       (rs_o),
        .rs_data_i  (rs_data_i),
        .stream     (bus)
    );

    // Behavioural regfile: combinational read of the addressed register.
    assign rs_data_i = regfile[rs_o];

    always #5 clk_i = ~clk_i;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // Runs one dump. Must be entered at a falling edge with the DUT idle.
    // mode 0: ready high, 1: random ready, 2: ready low for the first 7
    // valid cycles. abort_beat >= 0 aborts while that beat is offered.
    // inject_start pulses start with a different range while busy.
    task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l,
                                 input int mode, input int abort_beat,
                                 input bit inject_start);
        int          exp_count;
        int          exp_addr;
        int          k           = 0;
        int          cyc         = 0;
        int          done_cnt    = 0;
        int          done_cyc    = -1;
        int          first_valid = -1;
        int          last_hs     = -1;
        int          stall_left  = 7;
        bit          prev_stall  = 0;
        bit          aborted     = 0;
        logic [4:0]  prev_addr   = '0;
        logic [31:0] prev_data   = '0;

        exp_count = ((int'(l) - int'(f) + 32) % 32) + 1;

        start_i = 1'b1;
        first_i = f;
        last_i  = l;
        bus.m_ready_i = (mode == 0);
        @(negedge clk_i);
        start_i = 1'b0;
        first_i = ~f;
        last_i  = ~l;
        checkOutput("busy_after_start", busy_o, 1'b1);
        checkOutput("rs_first", rs_o, f);

        while (busy_o && cyc < 400 && !aborted) begin
            if (prev_stall) begin
                checkOutput("valid_hold", bus.m_valid_o, 1'b1);
                checkOutput("addr_hold", bus.m_addr_o, prev_addr);
                checkOutput("data_hold", bus.m_data_o, prev_data);
            end
            checkOutput("halt_eq_busy", halt_req_o, 1'b1);
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.m_valid_o && first_valid < 0) first_valid = cyc;

            case (mode)
                0: bus.m_ready_i = 1'b1;
                1: bus.m_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.m_valid_o && stall_left > 0) begin
                        bus.m_ready_i = 1'b0;
                        stall_left--;
                    end else begin
                        bus.m_ready_i = 1'b1;
                    end
                end
            endcase
            abort_i = (abort_beat >= 0) && bus.m_valid_o && (k == abort_beat);
            start_i = inject_start && (cyc == 3);
            if (start_i) begin
                first_i = 5'($urandom);
                last_i  = 5'($urandom);
            end

            if (bus.m_valid_o && bus.m_ready_i) begin
                if (abort_i) begin
                    aborted = 1;
                end else begin
                    exp_addr = (int'(f) + k) % 32;
                    checkOutput("beat_addr", bus.m_addr_o, exp_addr);
                    checkOutput("beat_data", bus.m_data_o, regfile[exp_addr]);
                    if (mode == 0 && last_hs >= 0)
                        checkOutput("beat_spacing", cyc - last_hs, 2);
                    last_hs = cyc;
                    k++;
                end
            end
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_addr  = bus.m_addr_o;
            prev_data  = bus.m_data_o;
            @(negedge clk_i);
            cyc++;
        end

        start_i = 1'b0;
        abort_i = 1'b0;
        checkOutput("cycle_budget", (cyc < 400), 1'b1);
        checkOutput("idle_valid_low", bus.m_valid_o, 1'b0);
        checkOutput("idle_busy_low", busy_o, 1'b0);
        checkOutput("idle_halt_low", halt_req_o, 1'b0);
        if (aborted) begin
            checkOutput("abort_beats", k, abort_beat);
            checkOutput("abort_no_done", done_cnt + int'(done_o), 0);
        end else begin
            checkOutput("beat_count", k, exp_count);
            checkOutput("done_count", done_cnt, 1);
            if (mode == 0) begin
                checkOutput("first_valid_latency", first_valid, 1);
                checkOutput("done_cycle", done_cyc, 2 * exp_count);
            end
        end
    endtask

    initial begin
        rst_in        = 1'b0;
        start_i       = 1'b0;
        abort_i       = 1'b0;
        first_i       = 5'd0;
        last_i        = 5'd0;
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) regfile[i] = 32'hA500_0000 + 32'(i);

        #1;
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_halt", halt_req_o, 1'b0);
        checkOutput("rst_done", done_o, 1'b0);
        checkOutput("rst_valid", bus.m_valid_o, 1'b0);
        checkOutput("rst_rs", rs_o, 5'd0);
        checkOutput("rst_addr", bus.m_addr_o, 5'd0);
        checkOutput("rst_data", bus.m_data_o, 32'd0);

        @(negedge clk_i);
        rst_in = 1'b1;
        @(negedge clk_i);

        // Full dump, then back-to-back wrapped and single-register dumps.
        applyStimulus(5'd0,  5'd31, 0, -1, 1'b0);
        applyStimulus(5'd30, 5'd1,  0, -1, 1'b0);
        applyStimulus(5'd5,  5'd5,  2, -1, 1'b0);

        // Random contents, random backpressure, start pulsed while busy.
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        applyStimulus(5'd0, 5'd31, 1, -1, 1'b1);

        // Abort while beat 3 is offered, then an immediate fresh dump.
        applyStimulus(5'd0, 5'd31, 0, 3, 1'b0);
        applyStimulus(5'd0, 5'd31, 0, -1, 1'b0);

        // A few random ranges under random backpressure.
        for (int i = 0; i < 3; i++)
            applyStimulus(5'($urandom), 5'($urandom), 1, -1, 1'b0);

        // Reset asserted while a beat is being offered.
        start_i       = 1'b1;
        first_i       = 5'd7;
        last_i        = 5'd20;
        bus.m_ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        checkOutput("pre_reset_valid", bus.m_valid_o, 1'b1);
        checkOutput("pre_reset_addr", bus.m_addr_o, 5'd7);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("midrst_busy", busy_o, 1'b0);
        checkOutput("midrst_halt", halt_req_o, 1'b0);
        checkOutput("midrst_done", done_o, 1'b0);
        checkOutput("midrst_valid", bus.m_valid_o, 1'b0);
        checkOutput("midrst_rs", rs_o, 5'd0);
        checkOutput("midrst_addr", bus.m_addr_o, 5'd0);
        checkOutput("midrst_data", bus.m_data_o, 32'd0);
        @(negedge clk_i);
        rst_in = 1'b1;
        @(negedge clk_i);
        applyStimulus(5'd28, 5'd3, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
